// File: rtl/car_motion.sv
// car_motion: key-driven car physics with frame-paced position integration and wall handling
module car_motion #(
  parameter int W = 11,
  parameter int VW = 8,
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int CAR_W = 64,
  parameter int CAR_L = 64,
  parameter int MARGIN = 5,
  parameter int SPEED_MAX = 50,
  parameter int ACCEL = 1,
  parameter int FRICTION = 1,
  parameter int FRAME_DIV = 1,
  parameter int BOUNCE = 0,
  parameter int X_INIT = 300,
  parameter int Y_INIT = 250
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          frame_ended,
  input  logic          enable,
  input  logic [3:0]    key,
  output logic [W-1:0]  xpos,
  output logic [W-1:0]  ypos,
  output logic [VW-1:0] xspeed,
  output logic [VW-1:0] yspeed,
  output logic          wall_hit,
  output logic          update_done
);
  localparam int DW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic signed [VW:0] ACC = (VW+1)'(ACCEL);
  localparam logic signed [VW:0] FRI = (VW+1)'(FRICTION);
  localparam logic signed [VW:0] SMAX = (VW+1)'(SPEED_MAX);
  localparam logic signed [W+1:0] LO_S = (W+2)'(MARGIN);
  localparam logic signed [W+1:0] XHI_S = (W+2)'(SCREEN_W - CAR_W);
  localparam logic signed [W+1:0] YHI_S = (W+2)'(SCREEN_H - CAR_L);
  localparam logic [W-1:0] LO_P = W'(MARGIN);
  localparam logic [W-1:0] XHI_P = W'(SCREEN_W - CAR_W);
  localparam logic [W-1:0] YHI_P = W'(SCREEN_H - CAR_L);
  typedef enum logic [1:0] {IDLE, VEL, POS, WALL} state_t;
  state_t state_q, state_d;
  logic fe_q, fe_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [VW-1:0] xspeed_q, xspeed_d, yspeed_q, yspeed_d;
  logic signed [W+1:0] xc_q, xc_d, yc_q, yc_d;
  logic wall_hit_q, wall_hit_d, update_done_q, update_done_d;
  logic cnt_en, wrap, tick, x_lo, x_hi, y_lo, y_hi;
  assign cnt_en = frame_ended & ~fe_q & enable;
  assign wrap = div_cnt_q == DIV_LAST;
  assign tick = cnt_en & wrap;
  assign x_lo = xc_q < LO_S;
  assign x_hi = xc_q > XHI_S;
  assign y_lo = yc_q < LO_S;
  assign y_hi = yc_q > YHI_S;
  // Wide arithmetic keeps accel/friction from wrapping before the saturation clamp
  function automatic logic [VW-1:0] vel_next(input logic [VW-1:0] v, input logic neg, input logic pos);
    logic signed [VW:0] w, r;
    w = $signed({v[VW-1], v});
    r = (neg & ~pos) ? w - ACC : (pos & ~neg) ? w + ACC : (w > FRI) ? w - FRI : (w < -FRI) ? w + FRI : '0;
    r = (r > SMAX) ? SMAX : (r < -SMAX) ? -SMAX : r;
    return r[VW-1:0];
  endfunction
  // State register
  always_ff @(posedge pclk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Ticks start an update only from IDLE; the rest of the pipeline advances unconditionally
  always_comb begin
    state_d = state_q == IDLE ? (tick ? VEL : IDLE) : state_q == VEL ? POS : state_q == POS ? WALL : IDLE;
  end
  // Divider, velocity, candidate position and wall resolution per state
  always_comb begin
    fe_d = frame_ended;
    div_cnt_d = cnt_en ? (wrap ? '0 : div_cnt_q + DW'(1)) : div_cnt_q;
    xspeed_d = xspeed_q;
    yspeed_d = yspeed_q;
    xc_d = xc_q;
    yc_d = yc_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    wall_hit_d = 1'b0;
    update_done_d = 1'b0;
    if (state_q == VEL) begin
      xspeed_d = vel_next(xspeed_q, key[2], key[3]);
      yspeed_d = vel_next(yspeed_q, key[0], key[1]);
    end
    if (state_q == POS) begin
      xc_d = $signed({2'b00, xpos_q}) + $signed({{(W+2-VW){xspeed_q[VW-1]}}, xspeed_q});
      yc_d = $signed({2'b00, ypos_q}) + $signed({{(W+2-VW){yspeed_q[VW-1]}}, yspeed_q});
    end
    if (state_q == WALL) begin
      xpos_d = x_lo ? LO_P : x_hi ? XHI_P : xc_q[W-1:0];
      ypos_d = y_lo ? LO_P : y_hi ? YHI_P : yc_q[W-1:0];
      xspeed_d = (x_lo | x_hi) ? (BOUNCE != 0 ? -xspeed_q : '0) : xspeed_q;
      yspeed_d = (y_lo | y_hi) ? (BOUNCE != 0 ? -yspeed_q : '0) : yspeed_q;
      wall_hit_d = x_lo | x_hi | y_lo | y_hi;
      update_done_d = 1'b1;
    end
  end
  // Datapath registers; reset mid-update discards the update in flight
  always_ff @(posedge pclk) begin
    if (rst) begin
      fe_q <= 1'b0;
      div_cnt_q <= '0;
      xpos_q <= W'(X_INIT);
      ypos_q <= W'(Y_INIT);
      xspeed_q <= '0;
      yspeed_q <= '0;
      xc_q <= '0;
      yc_q <= '0;
      wall_hit_q <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
      div_cnt_q <= div_cnt_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      xspeed_q <= xspeed_d;
      yspeed_q <= yspeed_d;
      xc_q <= xc_d;
      yc_q <= yc_d;
      wall_hit_q <= wall_hit_d;
      update_done_q <= update_done_d;
    end
  end
  assign xpos = xpos_q;
  assign ypos = ypos_q;
  assign xspeed = xspeed_q;
  assign yspeed = yspeed_q;
  assign wall_hit = wall_hit_q;
  assign update_done = update_done_q;
endmodule

// File: tb/tb_car_motion.sv
// tb_car_motion: directed vector bench for car_motion across several parameter sets
module tb_car_motion;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic fe = 1'b0;
  logic en = 1'b1;
  logic [3:0] key = 4'b0000;
  always #5 pclk = ~pclk;
  logic [10:0] m_xp, m_yp, b0_xp, b0_yp, b1_xp, b1_yp, y_xp, y_yp, d_xp, d_yp;
  logic [12:0] s_xp, s_yp;
  logic [7:0] m_xs, m_ys, b0_xs, b0_ys, b1_xs, b1_ys, y_xs, y_ys, s_xs, s_ys, d_xs, d_ys;
  logic m_wh, m_ud, b0_wh, b0_ud, b1_wh, b1_ud, y_wh, y_ud, s_wh, s_ud, d_wh, d_ud;
  car_motion dut (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(m_xp), .ypos(m_yp), .xspeed(m_xs), .yspeed(m_ys), .wall_hit(m_wh), .update_done(m_ud));
  car_motion #(.FRICTION(0), .BOUNCE(0), .X_INIT(900)) dut_b0 (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(b0_xp), .ypos(b0_yp), .xspeed(b0_xs), .yspeed(b0_ys), .wall_hit(b0_wh), .update_done(b0_ud));
  car_motion #(.FRICTION(0), .BOUNCE(1), .X_INIT(900)) dut_b1 (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(b1_xp), .ypos(b1_yp), .xspeed(b1_xs), .yspeed(b1_ys), .wall_hit(b1_wh), .update_done(b1_ud));
  car_motion #(.Y_INIT(14)) dut_y (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(y_xp), .ypos(y_yp), .xspeed(y_xs), .yspeed(y_ys), .wall_hit(y_wh), .update_done(y_ud));
  car_motion #(.W(13), .SCREEN_W(4096)) dut_s (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(s_xp), .ypos(s_yp), .xspeed(s_xs), .yspeed(s_ys), .wall_hit(s_wh), .update_done(s_ud));
  car_motion #(.FRAME_DIV(2)) dut_d2 (.pclk(pclk), .rst(rst), .frame_ended(fe), .enable(en), .key(key),
    .xpos(d_xp), .ypos(d_yp), .xspeed(d_xs), .yspeed(d_ys), .wall_hit(d_wh), .update_done(d_ud));
  int n_tests = 0;
  int n_fail = 0;
  int n_m = 0;
  int n_d2 = 0;
  logic hit_m, hit_b0, hit_b1, hit_y;
  always @(negedge pclk) begin
    if (m_ud) n_m++;
    if (d_ud) n_d2++;
  end
  typedef struct { logic [3:0] key; int xs; int xp; int ys; int yp; } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    fe = 1'b0;
    en = 1'b1;
    key = 4'b0000;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
  endtask
  task automatic tick(input logic exp_ud, input logic drop_en);
    @(negedge pclk);
    fe = 1'b1;
    @(negedge pclk);
    fe = 1'b0;
    if (drop_en) en = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("update_done_n2", int'(m_ud), 0);
    @(negedge pclk);
    chk("update_done_n3", int'(m_ud), int'(exp_ud));
    hit_m = m_wh;
    hit_b0 = b0_wh;
    hit_b1 = b1_wh;
    hit_y = y_wh;
    @(negedge pclk);
    chk("update_done_n4", int'(m_ud), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end
  initial begin
    int c0;
    tbl[0] = '{4'b1000, 1, 301, 0, 250};
    tbl[1] = '{4'b1000, 2, 303, 0, 250};
    tbl[2] = '{4'b1000, 3, 306, 0, 250};
    tbl[3] = '{4'b0100, 2, 308, 0, 250};
    tbl[4] = '{4'b1100, 1, 309, 0, 250};
    tbl[5] = '{4'b0001, 0, 309, -1, 249};
    tbl[6] = '{4'b0011, 0, 309, 0, 249};
    tbl[7] = '{4'b0010, 0, 309, 1, 250};
    tbl[8] = '{4'b0011, 0, 309, 0, 250};
    tbl[9] = '{4'b0100, -1, 308, 0, 250};
    do_reset();
    chk("rst_xpos", int'(m_xp), 300);
    chk("rst_ypos", int'(m_yp), 250);
    chk("rst_xspeed", int'($signed(m_xs)), 0);
    chk("rst_yspeed", int'($signed(m_ys)), 0);
    chk("rst_wall_hit", int'(m_wh), 0);
    chk("rst_update_done", int'(m_ud), 0);
    for (int t = 1; t <= 11; t++) begin
      key = t <= 3 ? 4'b1001 : t <= 10 ? 4'b1000 : 4'b0000;
      tick(1'b1, 1'b0);
      if (t == 3) begin
        chk("ywall_ypos_t3", int'(y_yp), 8);
        chk("ywall_yspeed_t3", int'($signed(y_ys)), -3);
      end
      if (t == 4) begin
        chk("ywall_ypos_t4", int'(y_yp), 6);
        chk("ywall_yspeed_t4", int'($signed(y_ys)), -2);
        chk("ywall_hit_t4", int'(hit_y), 0);
      end
      if (t == 5) begin
        chk("ywall_ypos_at_lo", int'(y_yp), 5);
        chk("ywall_yspeed_t5", int'($signed(y_ys)), -1);
        chk("ywall_hit_at_lo", int'(hit_y), 0);
      end
      if (t == 10) begin
        chk("b0_xpos_pre", int'(b0_xp), 955);
        chk("b0_xspeed_pre", int'($signed(b0_xs)), 10);
        chk("b0_hit_pre", int'(hit_b0), 0);
      end
      if (t == 11) begin
        chk("b0_xpos_clamp", int'(b0_xp), 960);
        chk("b0_xspeed_zero", int'($signed(b0_xs)), 0);
        chk("b0_hit", int'(hit_b0), 1);
        chk("b0_hit_pulse_end", int'(b0_wh), 0);
        chk("b1_xpos_clamp", int'(b1_xp), 960);
        chk("b1_xspeed_neg", int'($signed(b1_xs)), -10);
        chk("b1_hit", int'(hit_b1), 1);
      end
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key = tbl[i].key;
      tick(1'b1, 1'b0);
      chk("tbl_xspeed", int'($signed(m_xs)), tbl[i].xs);
      chk("tbl_xpos", int'(m_xp), tbl[i].xp);
      chk("tbl_yspeed", int'($signed(m_ys)), tbl[i].ys);
      chk("tbl_ypos", int'(m_yp), tbl[i].yp);
      chk("tbl_wall_hit", int'(hit_m), 0);
    end
    do_reset();
    key = 4'b1000;
    for (int t = 1; t <= 60; t++) begin
      tick(1'b1, 1'b0);
      chk("sat_xspeed", int'($signed(s_xs)), t < 50 ? t : 50);
    end
    chk("sat_xpos", int'(s_xp), 2075);
    key = 4'b0011;
    for (int k = 1; k <= 55; k++) begin
      tick(1'b1, 1'b0);
      chk("decay_xspeed", int'($signed(s_xs)), k < 50 ? 50 - k : 0);
      chk("both_y_as_none", int'($signed(s_ys)), 0);
    end
    chk("decay_xpos", int'(s_xp), 3300);
    chk("decay_ypos", int'(s_yp), 250);
    do_reset();
    c0 = n_d2;
    tick(1'b1, 1'b0);
    chk("div2_edge1", n_d2 - c0, 0);
    tick(1'b1, 1'b0);
    chk("div2_edge2", n_d2 - c0, 1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("div2_edge4", n_d2 - c0, 2);
    tick(1'b1, 1'b0);
    chk("div2_edge5", n_d2 - c0, 2);
    en = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    chk("div2_disabled", n_d2 - c0, 2);
    chk("disabled_xpos", int'(m_xp), 300);
    en = 1'b1;
    tick(1'b1, 1'b0);
    chk("div2_frozen_resume", n_d2 - c0, 3);
    tick(1'b1, 1'b1);
    en = 1'b1;
    key = 4'b1000;
    c0 = n_m;
    @(negedge pclk);
    fe = 1'b1;
    @(negedge pclk);
    fe = 1'b0;
    @(negedge pclk);
    chk("pos_xspeed", int'($signed(m_xs)), 1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    repeat (5) @(negedge pclk);
    chk("abort_no_done", n_m - c0, 0);
    chk("abort_xpos", int'(m_xp), 300);
    chk("abort_xspeed", int'($signed(m_xs)), 0);
    chk("abort_ypos", int'(m_yp), 250);
    chk("abort_wall_hit", int'(m_wh), 0);
    c0 = n_m;
    @(negedge pclk);
    fe = 1'b1;
    @(negedge pclk);
    fe = 1'b0;
    @(negedge pclk);
    fe = 1'b1;
    @(negedge pclk);
    fe = 1'b0;
    repeat (6) @(negedge pclk);
    chk("drop_count", n_m - c0, 1);
    chk("drop_xspeed", int'($signed(m_xs)), 1);
    chk("drop_xpos", int'(m_xp), 301);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/car_motion.md
# car_motion

Parametrised per-player car physics core for the racer display pipeline. It converts the 4-bit arrow-key vector into signed per-axis velocity with acceleration, friction and saturation. Velocity is integrated into a screen position once per N video frames, with clamp or bounce at the playfield walls. It sits between the keyboard decoder and the car sprite renderer, and updates are paced by the timing generator's `frame_ended` pulse instead of a free-running timer.

## Interface
- `W`, 11: position width in bits (unsigned).
- `VW`, 8: velocity width in bits (two's complement).
- `SCREEN_W`, 1024: playfield width in pixels.
- `SCREEN_H`, 768: playfield height in pixels.
- `CAR_W`, 64: car sprite width.
- `CAR_L`, 64: car sprite length.
- `MARGIN`, 5: low wall limit for both axes.
- `SPEED_MAX`, 50: velocity magnitude limit, must be < 2^(VW-1).
- `ACCEL`, 1: velocity step per tick while a key is held.
- `FRICTION`, 1: decay per tick on an axis with no key held; 0 disables decay.
- `FRAME_DIV`, 1: number of `frame_ended` rising edges per physics tick, ≥1.
- `BOUNCE`, 0: wall behaviour. 0 = clamp and zero velocity; 1 = clamp and negate velocity.
- `X_INIT`, 300: x position at reset.
- `Y_INIT`, 250: y position at reset.
- `pclk` input 1: pixel clock. All logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `frame_ended` input 1: end-of-frame pulse or level; its rising edge is counted.
- `enable` input 1: when low, ticks are ignored and the divider holds.
- `key` input 4: bit0 up, bit1 down, bit2 left, bit3 right.
- `xpos` output W: car left edge.
- `ypos` output W: car top edge.
- `xspeed` output VW: signed x velocity.
- `yspeed` output VW: signed y velocity.
- `wall_hit` output 1: one-cycle pulse when any axis was clamped in this update.
- `update_done` output 1: one-cycle pulse when a position update is complete.

## Operation
- Wall limits: `X_HI = SCREEN_W - CAR_W`, `Y_HI = SCREEN_H - CAR_L`, `LO = MARGIN` for both axes.
- Tick generation:
  - `frame_ended` is registered, and a rising edge is detected as (current & ~previous).
  - Each edge with `enable`=1 increments `div_cnt`.
  - When `div_cnt == FRAME_DIV-1`, `div_cnt` returns to 0 and a tick is issued.
- FSM states are IDLE, VEL, POS and WALL.
  - IDLE→VEL on a tick. Ticks are only accepted in IDLE; a tick arriving in any other state is dropped.
  - VEL→POS→WALL→IDLE unconditionally.
- VEL state: samples `key` and computes each axis independently.
  - Negative key only (up or left): `v - ACCEL`.
  - Positive key only (down or right): `v + ACCEL`.
  - Both keys or neither: apply friction. `v` moves toward 0 by `FRICTION` and never crosses zero (|v| ≤ FRICTION gives 0).
  - The result is saturated to ±`SPEED_MAX`.
  - Arithmetic is done at VW+1 bits signed before saturation, so no wrap is possible.
- POS state: candidate = `pos + v`, computed at W+2 bits signed, with `pos` zero-extended. The new velocity is used (semi-implicit Euler).
- WALL state, per axis:
  - If candidate < LO: `pos` = LO.
  - If candidate > HI: `pos` = HI.
  - Otherwise `pos` = candidate.
  - When an axis is clamped: `v` becomes 0 if `BOUNCE`=0, or `-v` if `BOUNCE`=1, and `wall_hit` is set.
  - Candidate equal to LO or HI is not a hit.
  - `update_done` is set.
- Reset values:
  - `xpos` = `X_INIT`, `ypos` = `Y_INIT`.
  - `xspeed` = `yspeed` = 0.
  - `wall_hit` = `update_done` = 0.
  - `div_cnt` = 0, FSM in IDLE, registered `frame_ended` = 0.
- Reset during VEL, POS or WALL aborts the update: no `update_done`, all registers take reset values.
- `enable` low mid-update does not abort; the current update completes.

## Timing
- Tick detected at edge N (state becomes VEL).
- Keys are sampled at edge N+1; `xspeed`/`yspeed` show the new values after N+1.
- Candidate is registered at edge N+2.
- `xpos`/`ypos`, any bounce/zero velocity correction, `wall_hit` and `update_done` become valid after N+3.
- Pulses deassert after N+4.
- Update latency is 3 cycles; throughput is one update per tick.
- Outputs are stable between updates. The renderer samples them after `update_done`.

## Test plan
- Reset with default parameters → `xpos`=300, `ypos`=250, `xspeed`=`yspeed`=0, `wall_hit`=`update_done`=0.
- Hold `key`=4'b1000 for 3 ticks → `xspeed` 1,2,3 and `xpos` 301,303,306. `update_done` is high exactly 3 cycles after each `frame_ended` edge.
- Hold right for 60 ticks → `xspeed` saturates at 50. Then release → `xspeed` decays 49,48,… to 0 and stays 0. `key`=4'b0011 behaves as no key on the y axis.
- `BOUNCE`=0, with `xpos`=955 and `xspeed`=+10 → `xpos`=960, `xspeed`=0, `wall_hit` high for 1 cycle. `BOUNCE`=1 with the same start → `xpos`=960, `xspeed`=-10.
- `ypos`=8, `yspeed`=-3, no keys, `FRICTION`=1 → `yspeed`=-2, then `ypos` 6, not a hit. Next tick: `yspeed`=-1, candidate 5 = LO, not a hit.
- `FRAME_DIV`=2 → updates on every 2nd `frame_ended` edge. `enable`=0 → no updates and `div_cnt` frozen. `rst` asserted in the POS state → reset values, no `update_done`.
